// File: rtl/qracc_output_requant.sv
`default_nettype none
// ============================================================================
// Module  : qracc_output_requant
// Purpose : Buffers accumulator vectors (2 entries), requantizes each lane
//           (rounded shift, ReLU, saturate) and streams fixed-width beats.
// Revision: 1.0 - initial release
// ============================================================================
module qracc_output_requant #(
    parameter int OUTPUT_ELEMENTS = 32,
    parameter int ACC_BITS        = 16,
    parameter int OUT_BITS        = 8,
    parameter int LANES_PER_BEAT  = 8,
    parameter int SHIFT_BITS      = 4,
    localparam int BEATS  = OUTPUT_ELEMENTS / LANES_PER_BEAT,
    localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [OUTPUT_ELEMENTS*ACC_BITS-1:0]  mac_data_i,
    input  logic                                 mac_valid_i,
    output logic                                 ready_o,
    input  logic [SHIFT_BITS-1:0]                shift_i,
    input  logic                                 relu_en_i,
    output logic [LANES_PER_BEAT*OUT_BITS-1:0]   data_o,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [BEAT_W-1:0]                    beat_idx_o,
    output logic                                 last_o,
    output logic                                 overflow_o,
    input  logic                                 overflow_clr_i
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    localparam logic signed [ACC_BITS:0] c_sat_max = (ACC_BITS+1)'((1 << (OUT_BITS-1)) - 1);
    localparam logic signed [ACC_BITS:0] c_sat_min = ~c_sat_max;

    logic [OUTPUT_ELEMENTS*ACC_BITS-1:0] r_data  [2];
    logic [SHIFT_BITS-1:0]               r_shift [2];
    logic                                r_relu  [2];

    logic [1:0]        r_count;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [BEAT_W-1:0] r_beat;
    logic [0:0]        r_state;
    logic              r_overflow;

    logic       w_last;
    logic       w_pop_last;
    logic       w_accept;
    logic       w_drop;
    logic [1:0] w_count_next;

    logic [OUTPUT_ELEMENTS*ACC_BITS-1:0] w_entry;
    logic [SHIFT_BITS-1:0]               w_shift;
    logic                                w_relu;
    logic [LANES_PER_BEAT*OUT_BITS-1:0]  w_beat;

    assign valid_o    = (r_state == S_STREAM);
    assign w_last     = (r_beat == BEAT_W'(BEATS-1));
    assign last_o     = valid_o && w_last;
    assign w_pop_last = valid_o && ready_i && w_last;
    // A vector leaving this cycle frees its slot for a simultaneous capture.
    assign w_accept   = mac_valid_i && ((r_count != 2'd2) || w_pop_last);
    assign w_drop     = mac_valid_i && (r_count == 2'd2) && !w_pop_last;
    assign w_count_next = r_count + {1'b0, w_accept} - {1'b0, w_pop_last};

    assign ready_o    = (r_count != 2'd2);
    assign beat_idx_o = r_beat;
    assign overflow_o = r_overflow;

    assign w_entry = r_data[r_rd_ptr];
    assign w_shift = r_shift[r_rd_ptr];
    assign w_relu  = r_relu[r_rd_ptr];

    generate
        for (genvar j = 0; j < LANES_PER_BEAT; j++) begin : g_lane
            logic signed [ACC_BITS-1:0] w_raw;
            logic signed [ACC_BITS:0]   w_round;
            logic signed [ACC_BITS:0]   w_sum;
            logic signed [ACC_BITS:0]   w_shr;
            logic signed [ACC_BITS:0]   w_rl;
            logic [OUT_BITS-1:0]        w_sat;

            assign w_raw   = w_entry[(32'(r_beat) * LANES_PER_BEAT + j) * ACC_BITS +: ACC_BITS];
            assign w_round = (w_shift == '0) ? '0 : ((ACC_BITS+1)'(1) << (w_shift - 1'b1));
            assign w_sum   = {w_raw[ACC_BITS-1], w_raw} + w_round;
            assign w_shr   = w_sum >>> w_shift;
            assign w_rl    = (w_relu && w_shr < 0) ? '0 : w_shr;
            assign w_sat   = (w_rl > c_sat_max) ? c_sat_max[OUT_BITS-1:0] :
                             (w_rl < c_sat_min) ? c_sat_min[OUT_BITS-1:0] :
                                                  w_rl[OUT_BITS-1:0];
            assign w_beat[j*OUT_BITS +: OUT_BITS] = w_sat;
        end
    endgenerate

    assign data_o = valid_o ? w_beat : '0;

    // Payload storage carries no reset; occupancy is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_data[r_wr_ptr]  <= mac_data_i;
            r_shift[r_wr_ptr] <= shift_i;
            r_relu[r_wr_ptr]  <= relu_en_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_wr_ptr   <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_beat     <= '0;
            r_state    <= S_IDLE;
            r_overflow <= 1'b0;
        end else begin
            r_count <= w_count_next;
            r_state <= (w_count_next != 2'd0) ? S_STREAM : S_IDLE;
            if (w_accept)
                r_wr_ptr <= ~r_wr_ptr;
            if (w_pop_last)
                r_rd_ptr <= ~r_rd_ptr;
            if (valid_o && ready_i)
                r_beat <= w_last ? '0 : r_beat + 1'b1;
            if (w_drop)
                r_overflow <= 1'b1;
            else if (overflow_clr_i)
                r_overflow <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: doc/qracc_output_requant.md
Name: qracc_output_requant

Overview:
- Downstream consumer of the sequential bit-serial MAC accumulator.
- Captures each full vector of signed accumulator results, pulsed for one cycle with no backpressure, into a 2-entry vector buffer.
- Requantizes each lane with a rounded arithmetic right shift, optional ReLU and signed saturation.
- Streams the vector out as fixed-width beats over a valid/ready interface, for the output SRAM or the next layer.

Parameters:
- outputElements, 32, lanes per input vector (must be a multiple of lanesPerBeat)
- accumulatorBits, 16, signed width of each input lane
- outBits, 8, signed width of each requantized lane
- lanesPerBeat, 8, lanes per output beat; beatsPerVector = outputElements/lanesPerBeat
- shiftBits, 4, width of the shift configuration field

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- mac_data_i  in  outputElements*accumulatorBits  signed accumulator lanes; lane i at [i]
- mac_valid_i  in  1  one-cycle capture strobe; cannot be stalled
- ready_o  out  1  buffer has a free slot (count<2); registered-state derived
- shift_i  in  shiftBits  right-shift amount, sampled at capture
- relu_en_i  in  1  ReLU enable, sampled at capture
- data_o  out  lanesPerBeat*outBits  requantized beat; lane j is vector lane beat_idx_o*lanesPerBeat+j
- valid_o  out  1  beat valid
- ready_i  in  1  downstream accepts beat
- beat_idx_o  out  clog2(beatsPerVector)  index of current beat
- last_o  out  1  current beat is the final beat of its vector (valid_o && beat_idx_o==beatsPerVector-1)
- overflow_o  out  1  sticky: a vector was dropped
- overflow_clr_i  in  1  clears overflow_o

Behaviour:
- Reset: all of the following clear on the next clk edge, including mid-stream, and the partially sent vector is discarded:
  - count, wr_ptr, rd_ptr, beat counter and overflow_o reset to 0.
  - valid_o=0, last_o=0, beat_idx_o=0, data_o=0, ready_o=1.
- Buffer: 2 entries. Each entry holds the raw mac_data_i plus the shift_i and relu_en_i values present at capture.
  - Config changes mid-stream never affect an already captured vector.
- Capture rules, per cycle:
  - pop_last = valid_o && ready_i && last_o.
  - Accept when mac_valid_i && (count<2 || pop_last). Write the entry at wr_ptr and toggle wr_ptr.
  - Drop when mac_valid_i && count==2 && !pop_last. Buffer is unchanged; overflow_o is set on the next cycle.
  - Count update: count += accept - pop_last. Simultaneous accept and pop_last leaves count unchanged.
- Overflow: overflow_clr_i clears overflow_o. If a drop and a clear occur in the same cycle, set wins.
- Output FSM (IDLE, STREAM):
  - IDLE: valid_o=0. Go to STREAM when count>0, i.e. on the cycle after a capture into an empty buffer. Latency from capture strobe to first valid_o is 1 cycle.
  - STREAM: valid_o=1. data_o is computed combinationally from the entry at rd_ptr and the beat counter.
  - A beat transfers on valid_o && ready_i. The beat counter increments, and wraps to 0 on the last beat.
  - On pop_last: toggle rd_ptr. Stay in STREAM if the post-update count>0, otherwise go to IDLE.
  - Back-to-back vectors stream with no bubble.
  - With ready_i=0, data_o, beat_idx_o and last_o hold stable.
- Per-lane arithmetic (signed, accumulatorBits+1 internal):
  - r = (a + (s>0 ? 2^(s-1) : 0)) >>> s, i.e. round-half-up.
  - If relu and r<0, r=0.
  - Saturate to [-2^(outBits-1), 2^(outBits-1)-1].
  - When s=0 the rounding term is 0.
- data_o = 0 whenever valid_o=0.

Test Plan:
- shift=4, relu=0, lanes 0..3 = 100, -100, 8, -8; single capture, ready_i=1 → beat 0 lanes 0..3 = 6, -6, 1, 0; 4 beats on consecutive cycles starting the cycle after capture; last_o only on beat 3; then IDLE.
- shift=2, lanes = 5000, -5000; relu=0 → 127, -128. Same with relu=1 → 127, 0. shift=0, lane -3, relu=0 → -3.
- Two captures 2 cycles apart, ready_i held 0 → ready_o falls after the second capture. Raise ready_i → 8 beats, the vectors in capture order, no gap between them. ready_o rises in the cycle after the first vector's last beat transfers.
- Buffer full, third mac_valid_i in the same cycle as pop_last → accepted, count stays 2, overflow_o stays 0. Fourth strobe while full and stalled → dropped, overflow_o=1 until overflow_clr_i. A clear coincident with a new drop leaves overflow_o=1.
- Change shift_i from 4 to 0 while vector A streams with ready_i toggling randomly → A's remaining beats still use shift 4. data_o is stable during every ready_i=0 cycle.
- Assert rst during beat 2 of a vector with a second vector buffered → next cycle valid_o=0, ready_o=1, overflow_o=0. A new capture then streams from beat 0.
